// File: rtl/ar_stride_gen.sv
// Address register with a built-in strided generator: loads from the bus or TR/MBR,
// then each Step advances by a column stride, adding a row skip at end of row.
module ar_stride_gen #(
  parameter int ADDR_W   = 16,
  parameter int COL_W    = 8,
  parameter int SAT_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   in_bus,
  input  logic                Write,
  input  logic                Ins_Con,
  input  logic [ADDR_W/2-1:0] TR_AR,
  input  logic [ADDR_W/2-1:0] MBR_AR,
  input  logic                Step,
  input  logic [ADDR_W-1:0]   Col_Stride,
  input  logic [ADDR_W-1:0]   Row_Skip,
  input  logic [COL_W-1:0]    Row_Len,
  output logic [ADDR_W-1:0]   out_bus,
  output logic [COL_W-1:0]    Col_Cnt,
  output logic                Row_End,
  output logic                Ovf
);

  localparam int HALF_W = ADDR_W / 2;

  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [COL_W-1:0]  col_cnt_reg, col_cnt_next;
  logic              row_end_reg, row_end_next;
  logic              ovf_reg, ovf_next;

  logic [COL_W-1:0]  row_len_eff;
  logic              row_last;
  logic [ADDR_W:0]   inc;
  logic [ADDR_W+1:0] sum;
  logic              carry;
  logic [ADDR_W-1:0] addr_on_carry;
  logic [ADDR_W-1:0] concat_load;

  assign concat_load = {TR_AR[HALF_W-1:0], MBR_AR[HALF_W-1:0]};

  // A zero row length behaves as one Step per row.
  assign row_len_eff = (Row_Len == '0) ? COL_W'(1) : Row_Len;
  // Strict equality: a counter already past a shrunk row length runs on and wraps.
  assign row_last    = (col_cnt_reg == row_len_eff - COL_W'(1));
  assign inc         = {1'b0, Col_Stride} + (row_last ? {1'b0, Row_Skip} : '0);
  assign sum         = {2'b00, addr_reg} + {1'b0, inc};
  assign carry       = |sum[ADDR_W+1:ADDR_W];

  generate
    if (SAT_MODE != 0) begin : g_sat
      assign addr_on_carry = '1;
    end else begin : g_wrap
      assign addr_on_carry = sum[ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    addr_next    = addr_reg;
    col_cnt_next = col_cnt_reg;
    row_end_next = 1'b0;
    ovf_next     = ovf_reg;
    if (Write) begin
      addr_next    = in_bus;
      col_cnt_next = '0;
      ovf_next     = 1'b0;
    end else if (Ins_Con) begin
      addr_next    = concat_load;
      col_cnt_next = '0;
      ovf_next     = 1'b0;
    end else if (Step) begin
      if (row_last) begin
        col_cnt_next = '0;
        row_end_next = 1'b1;
      end else begin
        col_cnt_next = col_cnt_reg + COL_W'(1);
      end
      if (carry) begin
        addr_next = addr_on_carry;
        ovf_next  = 1'b1;
      end else begin
        addr_next = sum[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg    <= '0;
      col_cnt_reg <= '0;
      row_end_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      addr_reg    <= addr_next;
      col_cnt_reg <= col_cnt_next;
      row_end_reg <= row_end_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign out_bus = addr_reg;
  assign Col_Cnt = col_cnt_reg;
  assign Row_End = row_end_reg;
  assign Ovf     = ovf_reg;

endmodule
